// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column output FIFOs below the MAC tile array.
// Each column writes its partial sum independently, whenever it is ready. A full row is
// presented, and popped as a unit, only when every column lane holds at least one entry.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   reset      - asynchronous active-high reset; clears the pointers and the overflow flag
//   in         - column psums; lane i = in[psum_bw*(i+1)-1 : psum_bw*i]
//   wr         - per-lane write strobe
//   rd         - pop one full row (ignored unless o_valid)
//   out        - head entry of every lane (first-word-fall-through); zero unless o_valid
//   o_valid    - every lane is non-empty
//   o_full     - at least one lane is full
//   o_ready    - ~o_full
//   o_overflow - sticky flag: a write was dropped on a full lane
module psum_ofifo #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);

  localparam int unsigned aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col-1:0]         wr_ok;
  logic [col*psum_bw-1:0] head;
  logic                   pop;
  logic                   ovf_set;

  // Pop is row-wide and only when every lane has data, so the lanes stay column-aligned.
  assign pop = rd & o_valid;

  for (genvar i = 0; i < col; i++) begin : g_lane
    logic [psum_bw-1:0] mem_q [depth];
    logic [aw:0]        wptr_q;
    logic [aw:0]        rptr_q;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign empty[i] = (wptr_q == rptr_q);
    assign full[i]  = (wptr_q[aw-1:0] == rptr_q[aw-1:0]) && (wptr_q[aw] != rptr_q[aw]);
    // Fullness is judged on the pre-edge pointers, so a write to a full lane is dropped
    // even when a pop frees a slot in the same cycle.
    assign wr_ok[i] = wr[i] & ~full[i];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr_ok[i]) wptr_q <= wptr_q + ptr_one;
        if (pop)      rptr_q <= rptr_q + ptr_one;
      end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
      if (wr_ok[i]) mem_q[wptr_q[aw-1:0]] <= in[psum_bw*i +: psum_bw];
    end

    assign head[psum_bw*i +: psum_bw] = mem_q[rptr_q[aw-1:0]];
  end

  assign ovf_set = |(wr & full);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_overflow <= 1'b0;
    end else if (ovf_set) begin
      o_overflow <= 1'b1;
    end
  end

  assign o_valid = &(~empty);
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign out     = o_valid ? head : '0;

endmodule

// File: tb/tb_psum_ofifo.sv
module tb_psum_ofifo;

  localparam int unsigned COL = 8;
  localparam int unsigned BW  = 16;
  localparam int unsigned DEP = 4;
  localparam int unsigned W   = COL * BW;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   din;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   dout;
  logic           o_valid, o_full, o_ready, o_overflow;

  int total = 0;
  int bad   = 0;

  psum_ofifo #(
    .col    (COL),
    .psum_bw(BW),
    .depth  (DEP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (din),
    .wr        (wr),
    .rd        (rd),
    .out       (dout),
    .o_valid   (o_valid),
    .o_full    (o_full),
    .o_ready   (o_ready),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [COL-1:0] wr;
    logic [W-1:0]   din;
    logic           rd;
    logic           ev;   // expected o_valid
    logic           ef;   // expected o_full (o_ready = ~ef)
    logic           eo;   // expected o_overflow
    logic [W-1:0]   eout;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [W-1:0] rowv(input logic [BW-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[BW*i +: BW] = v;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic flags(input string nm, input logic ev, input logic ef, input logic eo);
    chk1({nm, ".valid"}, o_valid, ev);
    chk1({nm, ".full"}, o_full, ef);
    chk1({nm, ".ready"}, o_ready, ~ef);
    chk1({nm, ".ovf"}, o_overflow, eo);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr = '0;
    rd = 1'b0;
    din = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r;
    reset = 1'b1;
    idle();
    #2;
    flags("rst_init", 1'b0, 1'b0, 1'b0);
    chk("rst_init.out", dout, '0);
    tick();
    reset = 1'b0;

    // Staggered fill: lane i gets 0x0100+i on cycle i, then one pop; then lane 3 overflow.
    r = '0;
    for (int i = 0; i < COL; i++) r[BW*i +: BW] = 16'h0100 + BW'(i);
    for (int i = 0; i < 8; i++) begin
      vecs[i].wr   = COL'(1) << i;
      vecs[i].din  = r;
      vecs[i].rd   = 1'b0;
      vecs[i].ev   = (i == 7);
      vecs[i].ef   = 1'b0;
      vecs[i].eo   = 1'b0;
      vecs[i].eout = (i == 7) ? r : '0;
    end
    vecs[8] = '{wr: '0, din: '0, rd: 1'b1, ev: 1'b0, ef: 1'b0, eo: 1'b0, eout: '0};
    for (int k = 0; k < 5; k++) begin
      vecs[9+k].wr   = 8'h08;
      vecs[9+k].din  = rowv(16'h0030 + BW'(k));
      vecs[9+k].rd   = 1'b0;
      vecs[9+k].ev   = 1'b0;
      vecs[9+k].ef   = (k >= 3);
      vecs[9+k].eo   = (k == 4);
      vecs[9+k].eout = '0;
    end

    for (int v = 0; v < 14; v++) begin
      wr  = vecs[v].wr;
      din = vecs[v].din;
      rd  = vecs[v].rd;
      tick();
      flags($sformatf("vec%0d", v), vecs[v].ev, vecs[v].ef, vecs[v].eo);
      chk($sformatf("vec%0d.out", v), dout, vecs[v].eout);
    end

    // Mid-cycle asynchronous reset with lanes partly filled and overflow set.
    wr = 8'h07;
    din = rowv(16'h0DDD);
    tick();
    idle();
    #2;
    reset = 1'b1;
    #1;
    flags("async_rst", 1'b0, 1'b0, 1'b0);
    chk("async_rst.out", dout, '0);
    #1;
    reset = 1'b0;
    wr = '1;
    din = rowv(16'hAAAA);
    tick();
    idle();
    flags("post_rst", 1'b1, 1'b0, 1'b0);
    chk("post_rst.out", dout, rowv(16'hAAAA));

    // Ordering across pointer wrap: three rows in flight, ten rows total.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wr = '1;
      din = rowv(BW'(k));
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("wrap%0d.out", k), dout, rowv(BW'(k)));
      flags($sformatf("wrap%0d", k), 1'b1, 1'b0, 1'b0);
      rd = 1'b1;
      wr = (k + 3 < 10) ? '1 : '0;
      din = rowv(BW'(k + 3));
      tick();
    end
    idle();
    flags("wrap_end", 1'b0, 1'b0, 1'b0);

    // Simultaneous read and write, lanes holding 2 entries.
    do_reset();
    wr = '1;
    din = rowv(16'h0011);
    tick();
    din = rowv(16'h0022);
    tick();
    chk("rw0.out", dout, rowv(16'h0011));
    rd = 1'b1;
    din = rowv(16'hBEEF);
    tick();
    chk("rw1.out", dout, rowv(16'h0022));
    tick();
    chk("rw2.out", dout, rowv(16'hBEEF));
    tick();
    chk("rw3.out", dout, rowv(16'hBEEF));
    flags("rw3", 1'b1, 1'b0, 1'b0);
    idle();
    rd = 1'b1;
    tick();
    chk("rw_drain1.out", dout, rowv(16'hBEEF));
    tick();
    idle();
    flags("rw_drain2", 1'b0, 1'b0, 1'b0);

    // Simultaneous read and write on full lanes: the write is dropped.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      wr = '1;
      din = rowv(BW'(k));
      tick();
    end
    idle();
    flags("rwf_full", 1'b1, 1'b1, 1'b0);
    rd = 1'b1;
    wr = '1;
    din = rowv(16'hBEEF);
    tick();
    idle();
    flags("rwf", 1'b1, 1'b0, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      chk($sformatf("rwf_pop%0d.out", k), dout, rowv(BW'(k)));
      rd = 1'b1;
      tick();
    end
    idle();
    flags("rwf_end", 1'b0, 1'b0, 1'b1);

    // Underflow: pop with all lanes empty is ignored.
    do_reset();
    rd = 1'b1;
    tick();
    idle();
    flags("uflow", 1'b0, 1'b0, 1'b0);
    wr = '1;
    din = rowv(16'h0077);
    tick();
    idle();
    flags("uflow_wr", 1'b1, 1'b0, 1'b0);
    chk("uflow_wr.out", dout, rowv(16'h0077));
    rd = 1'b1;
    tick();
    idle();
    flags("uflow_pop", 1'b0, 1'b0, 1'b0);
    chk("uflow_pop.out", dout, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
